sequenciador_exibicao: RTL and testbench

- Control unit that plays the stored jogada sequence back on the LEDs before each round of jogo_desafio_memoria.
- Walks memory addresses 0..limite and lights each stored value for a timed ON window, followed by a dark OFF gap.
- Latches `configuracao` and `limite_rodada` only at start; mid-sequence changes are ignored.
- Sits between the main unidade_controle, which issues iniciar and waits for pronto, and the datapath memory and LED driver.

---
 rtl/sequenciador_exibicao_pkg.sv | 22 ++
 rtl/sequenciador_exibicao_temporizador.sv | 27 ++
 rtl/sequenciador_exibicao.sv | 134 +++++++++++++
 tb/tb_sequenciador_exibicao.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sequenciador_exibicao_pkg.sv
// Shared definitions for the LED playback sequencer: state codes, config bit indices
// and the timer sizing helper.
package sequenciador_exibicao_pkg;

   typedef enum logic [4:0] {
      OCIOSO  = 5'b00000,
      CARREGA = 5'b00001,
      ACENDE  = 5'b00010,
      APAGA   = 5'b00011,
      FIM     = 5'b00100
   } estado_t;

   localparam int CFG_MODO   = 0;
   localparam int CFG_RAPIDO = 1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sequenciador_exibicao_temporizador.sv
// Loadable down-counter; fim is high on the cycle the count reaches 1, so a load of N
// spans exactly N cycles before the owner acts on fim.
module temporizador_exibicao #(
   parameter int W = 9
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic         i_carrega,
   input  logic [W-1:0] i_valor,
   output logic         o_fim
);

   logic [W-1:0] r_contagem;

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_contagem <= '0;
      end else if (i_carrega) begin
         r_contagem <= i_valor;
      end else if (r_contagem != '0) begin
         r_contagem <= r_contagem - 1'b1;
      end
   end

   assign o_fim = (r_contagem == W'(1));

endmodule

// File: rtl/sequenciador_exibicao.sv
// Replays stored jogada values on the LEDs: per item 1 load cycle + ON window + OFF gap,
// then a one-cycle pronto; abortar returns to idle at the next edge.
module sequenciador_exibicao
   import sequenciador_exibicao_pkg::*;
#(
   parameter int ADDR_W      = 4,
   parameter int T_ON        = 500,
   parameter int T_ON_RAPIDO = 250,
   parameter int T_OFF       = 200,
   parameter int DEMO_LIMITE = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              abortar,
   input  logic [1:0]        configuracao,
   input  logic [ADDR_W-1:0] limite_rodada,
   input  logic [3:0]        dado_memoria,
   output logic [ADDR_W-1:0] endereco,
   output logic [3:0]        leds,
   output logic              ocupado,
   output logic              pronto,
   output logic              db_modo,
   output logic [4:0]        db_estado
);

   localparam int TW = $clog2(max3(T_ON, T_ON_RAPIDO, T_OFF) + 1);

   if (T_ON <= 0 || T_ON_RAPIDO <= 0 || T_OFF <= 0) begin : g_param_invalido
      $error("sequenciador_exibicao: T_ON, T_ON_RAPIDO and T_OFF must be nonzero");
   end

   estado_t           r_estado;
   logic [ADDR_W-1:0] r_endereco;
   logic [ADDR_W-1:0] r_limite_ef;
   logic [3:0]        r_leds;
   logic              r_modo;
   logic              r_rapido;

   logic [ADDR_W-1:0] w_limite_ef;
   logic              w_carrega;
   logic [TW-1:0]     w_valor;
   logic              w_fim;

   // Demo mode clamps the last address shown to DEMO_LIMITE.
   always_comb begin
      w_limite_ef = limite_rodada;
      if (configuracao[CFG_MODO] && (limite_rodada > ADDR_W'(DEMO_LIMITE))) begin
         w_limite_ef = ADDR_W'(DEMO_LIMITE);
      end
   end

   always_comb begin
      w_carrega = 1'b0;
      w_valor   = TW'(T_OFF);
      if (reset && !abortar) begin
         if (r_estado == CARREGA) begin
            w_carrega = 1'b1;
            w_valor   = r_rapido ? TW'(T_ON_RAPIDO) : TW'(T_ON);
         end else if (r_estado == ACENDE && w_fim) begin
            w_carrega = 1'b1;
         end
      end
   end

   temporizador_exibicao #(.W(TW)) u_temporizador (
      .i_clock   (clock),
      .i_reset   (reset),
      .i_carrega (w_carrega),
      .i_valor   (w_valor),
      .o_fim     (w_fim)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_estado    <= OCIOSO;
         r_endereco  <= '0;
         r_limite_ef <= '0;
         r_leds      <= '0;
         r_modo      <= 1'b0;
         r_rapido    <= 1'b0;
      end else if (abortar && r_estado != OCIOSO) begin
         r_estado <= OCIOSO;
         r_leds   <= '0;
      end else begin
         case (r_estado)
            OCIOSO: begin
               if (iniciar && !abortar) begin
                  r_modo      <= configuracao[CFG_MODO];
                  r_rapido    <= configuracao[CFG_RAPIDO];
                  r_limite_ef <= w_limite_ef;
                  r_endereco  <= '0;
                  r_estado    <= CARREGA;
               end
            end
            CARREGA: begin
               r_leds   <= dado_memoria;
               r_estado <= ACENDE;
            end
            ACENDE: begin
               if (w_fim) begin
                  r_leds   <= '0;
                  r_estado <= APAGA;
               end
            end
            APAGA: begin
               if (w_fim) begin
                  if (r_endereco == r_limite_ef) begin
                     r_estado <= FIM;
                  end else begin
                     r_endereco <= r_endereco + 1'b1;
                     r_estado   <= CARREGA;
                  end
               end
            end
            FIM: begin
               r_estado <= OCIOSO;
            end
            default: begin
               r_estado <= OCIOSO;
               r_leds   <= '0;
            end
         endcase
      end
   end

   assign endereco  = r_endereco;
   assign leds      = r_leds;
   assign db_modo   = r_modo;
   assign db_estado = r_estado;
   assign ocupado   = (r_estado != OCIOSO);
   assign pronto    = (r_estado == FIM);

endmodule

// File: tb/tb_sequenciador_exibicao.sv
// Bench for sequenciador_exibicao with short timing parameters; a per-cycle schedule
// model plus hand-computed point checks.
module tb_sequenciador_exibicao;

   localparam int TON  = 4;
   localparam int TONR = 2;
   localparam int TOFF = 2;
   localparam int DEMO = 1;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       iniciar = 1'b0;
   logic       abortar = 1'b0;
   logic [1:0] configuracao = 2'b00;
   logic [3:0] limite_rodada = 4'd0;
   logic [3:0] dado_memoria;
   logic [3:0] endereco;
   logic [3:0] leds;
   logic       ocupado;
   logic       pronto;
   logic       db_modo;
   logic [4:0] db_estado;

   logic [3:0] mem [16];

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   int m_act  = 0;
   int m_t    = 0;
   int m_lim  = 0;
   int m_ton  = TON;
   int m_modo = 0;
   int m_end  = 0;

   sequenciador_exibicao #(
      .ADDR_W(4), .T_ON(TON), .T_ON_RAPIDO(TONR), .T_OFF(TOFF), .DEMO_LIMITE(DEMO)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .iniciar       (iniciar),
      .abortar       (abortar),
      .configuracao  (configuracao),
      .limite_rodada (limite_rodada),
      .dado_memoria  (dado_memoria),
      .endereco      (endereco),
      .leds          (leds),
      .ocupado       (ocupado),
      .pronto        (pronto),
      .db_modo       (db_modo),
      .db_estado     (db_estado)
   );

   always #5 clock = ~clock;

   // Memory read data follows the registered address.
   assign dado_memoria = mem[endereco];

   function automatic int periodo();
      return 1 + m_ton + TOFF;
   endfunction

   function automatic int addr_of(input int t);
      if (t > (m_lim + 1) * periodo()) return m_lim;
      return (t - 1) / periodo();
   endfunction

   // Schedule model: m_t counts cycles since the accepted start (1 = load cycle).
   always @(posedge clock) begin
      if (!reset) begin
         m_act = 0; m_t = 0; m_end = 0; m_modo = 0;
      end else if (m_act != 0) begin
         if (abortar) begin
            m_act = 0;
         end else begin
            m_t = m_t + 1;
            if (m_t > (m_lim + 1) * periodo() + 1) m_act = 0;
            else m_end = addr_of(m_t);
         end
      end else if (iniciar && !abortar) begin
         m_modo = int'(configuracao[0]);
         m_ton  = configuracao[1] ? TONR : TON;
         m_lim  = (m_modo != 0 && int'(limite_rodada) > DEMO) ? DEMO : int'(limite_rodada);
         m_act  = 1;
         m_t    = 1;
         m_end  = 0;
      end
   end

   always @(negedge clock) begin
      logic [4:0] e_est;
      logic [3:0] e_leds;
      logic [3:0] e_end;
      logic       e_pr, e_oc, e_modo;
      int         ph;
      if (chk_en) begin
         e_est = 5'd0; e_leds = 4'd0; e_end = 4'(m_end); e_pr = 1'b0; e_oc = 1'b0;
         e_modo = (m_modo != 0);
         if (m_act != 0) begin
            e_oc = 1'b1;
            if (m_t <= (m_lim + 1) * periodo()) begin
               ph = (m_t - 1) % periodo();
               if (ph == 0) e_est = 5'd1;
               else if (ph <= m_ton) begin
                  e_est = 5'd2;
                  e_leds = mem[m_end];
               end else e_est = 5'd3;
            end else begin
               e_est = 5'd4;
               e_pr  = 1'b1;
            end
         end
         n_total++;
         if ({db_estado, leds, endereco, pronto, ocupado, db_modo} ===
             {e_est, e_leds, e_end, e_pr, e_oc, e_modo}) begin
            n_pass++;
         end else begin
            $display("FAIL model_cycle @%0t: got est=%0d leds=%b end=%0d pronto=%b ocup=%b modo=%b, want est=%0d leds=%b end=%0d pronto=%b ocup=%b modo=%b",
                     $time, db_estado, leds, endereco, pronto, ocupado, db_modo,
                     e_est, e_leds, e_end, e_pr, e_oc, e_modo);
         end
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s (cycle %0d): got %0d expected %0d", nm, cyc, got, exp);
   endtask

   task automatic tick();
      @(negedge clock);
      cyc++;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic start(input logic [1:0] cfg, input logic [3:0] lim);
      configuracao  = cfg;
      limite_rodada = lim;
      iniciar       = 1'b1;
      cyc           = 0;
      tick();
      iniciar       = 1'b0;
   endtask

   initial begin
      mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100; mem[3] = 4'b1000;
      for (int i = 4; i < 16; i++) mem[i] = 4'b0000;

      repeat (3) @(negedge clock);
      chk_en = 1'b1;
      chk("reset_estado", int'(db_estado), 0);
      chk("reset_outputs", int'({leds, endereco, pronto, ocupado, db_modo}), 0);
      reset = 1'b1;
      tick();

      // Normal run
      start(2'b00, 4'd2);
      wait_to(2);  chk("norm_leds_c2", int'(leds), 1);
      wait_to(5);  chk("norm_leds_c5", int'(leds), 1);
      wait_to(6);  chk("norm_leds_c6", int'(leds), 0);
      wait_to(9);  chk("norm_leds_c9", int'(leds), 2);
      wait_to(12); chk("norm_leds_c12", int'(leds), 2);
      wait_to(16); chk("norm_leds_c16", int'(leds), 4);
      wait_to(19); chk("norm_leds_c19", int'(leds), 4);
      wait_to(21); chk("norm_pronto_c21", int'(pronto), 0);
      wait_to(22); chk("norm_pronto_c22", int'(pronto), 1);
      wait_to(23); chk("norm_ocupado_c23", int'(ocupado), 0);
      chk("norm_endereco_hold", int'(endereco), 2);
      wait_to(26);

      // Fast mode
      start(2'b10, 4'd1);
      wait_to(3);  chk("fast_leds_c3", int'(leds), 1);
      wait_to(4);  chk("fast_leds_c4", int'(leds), 0);
      wait_to(7);  chk("fast_leds_c7", int'(leds), 2);
      wait_to(11); chk("fast_pronto_c11", int'(pronto), 1);
      wait_to(14);

      // Demo clamp
      start(2'b01, 4'd3);
      wait_to(1);  chk("demo_db_modo", int'(db_modo), 1);
      wait_to(9);  chk("demo_leds_c9", int'(leds), 2);
      wait_to(15); chk("demo_pronto_c15", int'(pronto), 1);
      chk("demo_endereco", int'(endereco), 1);
      wait_to(18);

      // Config change mid-run is ignored
      start(2'b01, 4'd2);
      wait_to(3);  configuracao = 2'b00; limite_rodada = 4'd3;
      wait_to(10); chk("cfgchg_db_modo", int'(db_modo), 1);
      wait_to(15); chk("cfgchg_pronto_c15", int'(pronto), 1);
      wait_to(16); chk("cfgchg_ocupado_c16", int'(ocupado), 0);
      wait_to(18);

      // Abort, ignored restart while busy, abort+start in idle
      start(2'b00, 4'd2);
      wait_to(6);  iniciar = 1'b1;
      tick();      iniciar = 1'b0;
      chk("busy_start_ignored_addr", int'(endereco), 0);
      wait_to(10); abortar = 1'b1;
      tick();      abortar = 1'b0;
      chk("abort_estado", int'(db_estado), 0);
      chk("abort_leds", int'(leds), 0);
      wait_to(24); chk("abort_no_pronto", int'(pronto), 0);
      iniciar = 1'b1; abortar = 1'b1;
      tick();
      iniciar = 1'b0; abortar = 1'b0;
      chk("abort_wins_estado", int'(db_estado), 0);
      chk("abort_wins_ocupado", int'(ocupado), 0);
      wait_to(28);

      // Reset mid-sequence, then a fresh run
      start(2'b01, 4'd2);
      wait_to(6);  reset = 1'b0;
      tick();      reset = 1'b1;
      chk("rst_mid_estado", int'(db_estado), 0);
      chk("rst_mid_outputs", int'({leds, endereco, pronto, ocupado, db_modo}), 0);
      tick();
      start(2'b00, 4'd1);
      wait_to(2);  chk("fresh_endereco_c2", int'(endereco), 0);
      chk("fresh_leds_c2", int'(leds), 1);
      wait_to(15); chk("fresh_pronto_c15", int'(pronto), 1);
      wait_to(18);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
